// File: rtl/mult_4bits_seq.sv
// Sequential 4x4 unsigned shift-add multiplier: 4 iterations, one per clock.
// Optional macro MULT_ZERO_SKIP_EN: a zero operand jumps straight to DONE.
module mult_4bits_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);

    localparam int unsigned OP_W   = 4;
    localparam int unsigned PROD_W = 8;
    localparam int unsigned P_W    = 9;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_d;
    logic [OP_W-1:0]     m, m_d;
    logic [P_W-1:0]      p, p_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [PROD_W-1:0]   product_d;
    logic                busy_d, done_d;
    logic [OP_W:0]       sum_c;
    logic [P_W-1:0]      acc_c;

    // Bit-level ripple adder, no carry-in; returns {carry_out, sum}.
    function automatic logic [OP_W:0] ripple_add4(input logic [OP_W-1:0] x,
                                                  input logic [OP_W-1:0] y);
        logic [OP_W-1:0] s;
        logic            c;
        c = 1'b0;
        s = '0;
        for (int i = 0; i < OP_W; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    // One iteration: conditional add into hi, then logical shift right.
    always_comb begin
        sum_c = ripple_add4(p[2*OP_W-1:OP_W], m);
        acc_c = p[0] ? {sum_c, p[OP_W-1:0]} : {1'b0, p[2*OP_W-1:0]};
    end

    always_comb begin
        state_d   = state;
        m_d       = m;
        p_d       = p;
        cnt_d     = cnt;
        product_d = product;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
`ifdef MULT_ZERO_SKIP_EN
                    if ((a == 4'h0) || (b == 4'h0)) begin
                        state_d   = DONE;
                        product_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        state_d = CALC;
                        m_d     = a;
                        p_d     = {1'b0, 4'h0, b};
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end
`else
                    state_d = CALC;
                    m_d     = a;
                    p_d     = {1'b0, 4'h0, b};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
`endif
                end
            end
            CALC: begin
                p_d   = {1'b0, acc_c[P_W-1:1]};
                cnt_d = cnt + CNT_W'(1);
                if (cnt == CNT_W'(3)) begin
                    state_d   = DONE;
                    product_d = p_d[PROD_W-1:0];
                    done_d    = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            m       <= '0;
            p       <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            m       <= m_d;
            p       <= p_d;
            cnt     <= cnt_d;
            product <= product_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_mult_4bits_seq.sv
// Self-checking bench for mult_4bits_seq: vector table, corner sequences, full sweep.
module tb_mult_4bits_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_hold = 8'h00;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[7];

    mult_4bits_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse pops one expected product; otherwise product must hold.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_hold = exp_q.pop_front();
                chk("product_on_done", int'(product), int'(exp_hold));
            end
        end else begin
            chk("product_hold", int'(product), int'(exp_hold));
        end
    end

    // Issue one operation and check the busy/done timeline.
    task automatic run_op(input logic [3:0] ai, input logic [3:0] bi, input logic [7:0] exp);
        int  nbusy;
        bit  skip;
        skip = 1'b0;
`ifdef MULT_ZERO_SKIP_EN
        skip = (ai == 4'h0) || (bi == 4'h0);
`endif
        nbusy = skip ? 0 : 4;
        @(posedge clk);
        #1;
        start = 1'b1;
        a     = ai;
        b     = bi;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 4'($urandom);
        b     = 4'($urandom);
        for (int i = 0; i < nbusy; i++) begin
            @(negedge clk);
            chk("busy_phase_busy", int'(busy), 1);
            chk("busy_phase_done", int'(done), 0);
        end
        @(negedge clk);
        chk("done_phase_busy", int'(busy), 0);
        chk("done_phase_done", int'(done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{a: 4'd15, b: 4'd15, exp: 8'hE1};
        tbl[1] = '{a: 4'd0,  b: 4'd9,  exp: 8'd0};
        tbl[2] = '{a: 4'd3,  b: 4'd5,  exp: 8'd15};
        tbl[3] = '{a: 4'd7,  b: 4'd6,  exp: 8'd42};
        tbl[4] = '{a: 4'd9,  b: 4'd0,  exp: 8'd0};
        tbl[5] = '{a: 4'd1,  b: 4'd15, exp: 8'd15};
        tbl[6] = '{a: 4'd8,  b: 4'd8,  exp: 8'd64};

        rst   = 1'b1;
        start = 1'b0;
        a     = 4'h0;
        b     = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_product", int'(product), 0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors, issued back-to-back at the minimum interval.
        foreach (tbl[i]) run_op(tbl[i].a, tbl[i].b, tbl[i].exp);

        // A few idle cycles: product must hold the last result.
        repeat (4) @(posedge clk);

        // start held high for 12 cycles: accepted only at edges N and N+6.
        @(posedge clk);
        #1;
        start = 1'b1;
        a     = 4'd2;
        b     = 4'd3;
        exp_q.push_back(8'd6);
        exp_q.push_back(8'd6);
        repeat (12) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        chk("held_start_drained", exp_q.size(), 0);

        // Reset during the second busy cycle of 9*9 aborts without a done pulse.
        @(posedge clk);
        #1;
        start = 1'b1;
        a     = 4'd9;
        b     = 4'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst      = 1'b1;
        exp_hold = 8'h00;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_product", int'(product), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        run_op(4'd9, 4'd9, 8'd81);

        // Exhaustive sweep against the arithmetic reference.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                run_op(4'(ai), 4'(bi), 8'(ai * bi));
            end
        end

        repeat (4) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
